// File: rtl/data_pkg.sv
// Shared constants and payload types for the datapath slice.
package data_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_COUNT = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned UI_W      = 10;

    typedef enum logic [OP_W-1:0] {
        OP_3R  = 3'b000,
        OP_2RI = 3'b001,
        OP_RI  = 3'b010,
        OP_L   = 3'b011,
        OP_UJ  = 3'b100
    } opcode_t;

    // One register-file writeback request.
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

endpackage

// File: rtl/data_reg_file.sv
// 8 x 16 register file: two asynchronous read ports, one synchronous write port.
module reg_file
    import data_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  wb_t               wb,
    input  logic [ADDR_W-1:0] read_a_address,
    input  logic [ADDR_W-1:0] read_b_address,
    output logic [DATA_W-1:0] read_a_data_c,
    output logic [DATA_W-1:0] read_b_data_c
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // Storage: cleared asynchronously, loaded only on an enabled edge (r0 is ordinary).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (wb.en) begin
            regs[wb.addr] <= wb.data;
        end
    end

    // Reads see the stored value only; no bypass from the pending write.
    always_comb begin
        read_a_data_c = regs[read_a_address];
        read_b_data_c = regs[read_b_address];
    end

endmodule

// File: rtl/data.sv
// Decode-stage datapath: register file, writeback mux and immediate generator.
module data
    import data_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] input_reg_readA_address,
    input  logic [ADDR_W-1:0] input_reg_readB_address,
    input  logic              input_reg_write,
    input  logic [ADDR_W-1:0] input_reg_write_address,
    input  logic [DATA_W-1:0] input_ALUOut,
    input  logic [DATA_W-1:0] input_MDR,
    input  logic              memToReg,
    input  logic [DATA_W-1:0] input_imm,
    input  logic              input_branch,
    output logic [DATA_W-1:0] output_reg_A,
    output logic [DATA_W-1:0] output_reg_B,
    output logic [DATA_W-1:0] output_imm
);

    wb_t               wb;
    opcode_t           opcode;
    logic [UI_W-1:0]   ui;
    logic [DATA_W-1:0] imm_2ri;

    // Writeback mux: memory data or ALU result.
    always_comb begin
        wb.en   = input_reg_write;
        wb.addr = input_reg_write_address;
        wb.data = memToReg ? input_MDR : input_ALUOut;
    end

    reg_file u_reg_file (
        .clk            (CLK),
        .rst_n          (RESET_N),
        .wb             (wb),
        .read_a_address (input_reg_readA_address),
        .read_b_address (input_reg_readB_address),
        .read_a_data_c  (output_reg_A),
        .read_b_data_c  (output_reg_B)
    );

    // Upper-immediate register: captured by an L-type word, kept across everything else.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ui <= '0;
        end else if (opcode == OP_L) begin
            ui <= input_imm[12:3];
        end
    end

    // Immediate generator; branch mode doubles the 2RI offset regardless of opcode.
    always_comb begin
        opcode     = opcode_t'(input_imm[OP_W-1:0]);
        imm_2ri    = {{(DATA_W-7){input_imm[15]}}, input_imm[15:9]};
        output_imm = '0;
        case (opcode)
            OP_RI:   output_imm = {ui, input_imm[12:7]};
            OP_UJ:   output_imm = {{(DATA_W-9){input_imm[12]}}, input_imm[12:4]};
            OP_2RI:  output_imm = imm_2ri;
            default: output_imm = '0;
        endcase
        if (input_branch) begin
            output_imm = {imm_2ri[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_data.sv
// Directed scoreboard bench for the data datapath slice.
module tb_data;

    localparam int SEL_A   = 0;
    localparam int SEL_B   = 1;
    localparam int SEL_IMM = 2;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [2:0]  input_reg_readA_address = '0;
    logic [2:0]  input_reg_readB_address = '0;
    logic        input_reg_write = 1'b0;
    logic [2:0]  input_reg_write_address = '0;
    logic [15:0] input_ALUOut = '0;
    logic [15:0] input_MDR = '0;
    logic        memToReg = 1'b0;
    logic [15:0] input_imm = '0;
    logic        input_branch = 1'b0;
    logic [15:0] output_reg_A;
    logic [15:0] output_reg_B;
    logic [15:0] output_imm;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    data dut (
        .CLK                     (CLK),
        .RESET_N                 (RESET_N),
        .input_reg_readA_address (input_reg_readA_address),
        .input_reg_readB_address (input_reg_readB_address),
        .input_reg_write         (input_reg_write),
        .input_reg_write_address (input_reg_write_address),
        .input_ALUOut            (input_ALUOut),
        .input_MDR               (input_MDR),
        .memToReg                (memToReg),
        .input_imm               (input_imm),
        .input_branch            (input_branch),
        .output_reg_A            (output_reg_A),
        .output_reg_B            (output_reg_B),
        .output_imm              (output_imm)
    );

    always #5 CLK = ~CLK;

    task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    // Let outputs settle, then compare every pending expectation.
    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                SEL_A:   obs = output_reg_A;
                SEL_B:   obs = output_reg_B;
                default: obs = output_imm;
            endcase
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge with write dropped.
    task automatic do_write(input logic [2:0] addr, input logic [15:0] val, input logic mdr);
        input_reg_write         = 1'b1;
        input_reg_write_address = addr;
        memToReg                = mdr;
        if (mdr) begin
            input_MDR    = val;
            input_ALUOut = ~val;
        end else begin
            input_ALUOut = val;
            input_MDR    = ~val;
        end
        @(posedge CLK);
        @(negedge CLK);
        input_reg_write = 1'b0;
    endtask

    task automatic read_pair(input logic [2:0] a, input logic [2:0] b,
                             input logic [15:0] ea, input logic [15:0] eb, input string tag);
        input_reg_readA_address = a;
        input_reg_readB_address = b;
        expect_out({tag, "_A"}, SEL_A, ea);
        expect_out({tag, "_B"}, SEL_B, eb);
        check_all();
    endtask

    initial begin
        // Reset state: every register reads zero, immediate zero.
        #2;
        for (int i = 0; i < 8; i++) begin
            read_pair(3'(i), 3'(7 - i), 16'h0000, 16'h0000, $sformatf("rst_r%0d", i));
        end
        expect_out("rst_imm", SEL_IMM, 16'h0000);
        check_all();
        @(negedge CLK);
        RESET_N = 1'b1;

        // Three MDR writes, then read back.
        do_write(3'd0, 16'h0001, 1'b1);
        do_write(3'd1, 16'h0005, 1'b1);
        do_write(3'd2, 16'h0010, 1'b1);
        read_pair(3'd0, 3'd1, 16'h0001, 16'h0005, "wr_mdr");
        read_pair(3'd2, 3'd3, 16'h0010, 16'h0000, "wr_r2");

        // Read-during-write of r2 through the ALU path: old value until the edge.
        input_reg_readA_address = 3'd2;
        input_reg_write         = 1'b1;
        input_reg_write_address = 3'd2;
        memToReg                = 1'b0;
        input_ALUOut            = 16'h1234;
        input_MDR               = 16'hDEAD;
        expect_out("rdw_before", SEL_A, 16'h0010);
        check_all();
        @(posedge CLK);
        expect_out("rdw_after", SEL_A, 16'h1234);
        check_all();
        @(negedge CLK);
        input_reg_write = 1'b0;

        // Write enable low: nothing changes.
        input_reg_write_address = 3'd3;
        input_ALUOut            = 16'hBEEF;
        input_MDR               = 16'hBEEF;
        @(posedge CLK);
        @(negedge CLK);
        read_pair(3'd3, 3'd2, 16'h0000, 16'h1234, "nowr");

        // Top register is writable too.
        do_write(3'd7, 16'h7777, 1'b0);
        read_pair(3'd0, 3'd7, 16'h0001, 16'h7777, "wr_r7");

        // L-type with zero upper field, then RI.
        input_imm = 16'b0000000000000_011;
        expect_out("l_zero", SEL_IMM, 16'h0000);
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        input_imm = 16'b100_000001_0110_010;
        expect_out("ri_ui0", SEL_IMM, 16'h0001);
        check_all();

        // L-type loading a nonzero UI, then RI combines it.
        input_imm = {3'b000, 10'h2A5, 3'b011};
        expect_out("l_nz", SEL_IMM, 16'h0000);
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        input_imm = {3'b000, 6'h15, 4'h0, 3'b010};
        expect_out("ri_ui", SEL_IMM, {10'h2A5, 6'h15});
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        input_imm = {3'b111, 6'h2A, 4'hF, 3'b010};
        expect_out("ri_keep", SEL_IMM, {10'h2A5, 6'h2A});
        check_all();

        // Opcodes without an immediate give zero even with UI loaded.
        input_imm = 16'hFFF8;
        expect_out("op3r", SEL_IMM, 16'h0000);
        check_all();
        input_imm = 16'hFFFD;
        expect_out("op101", SEL_IMM, 16'h0000);
        check_all();
        input_imm = 16'hFFFF;
        expect_out("op111", SEL_IMM, 16'h0000);
        check_all();

        // UJ: 9-bit field at [12:4], sign-extended.
        input_imm = {3'b000, 9'b000001101, 4'b0100};
        expect_out("uj_pos", SEL_IMM, 16'h000D);
        check_all();
        input_imm = {3'b000, 9'b100000000, 4'b0100};
        expect_out("uj_neg", SEL_IMM, 16'hFF00);
        check_all();

        // 2RI and branch offset.
        input_imm = 16'b1111111_000000_001;
        expect_out("2ri_neg", SEL_IMM, 16'hFFFF);
        check_all();
        input_branch = 1'b1;
        expect_out("br_neg", SEL_IMM, 16'hFFFE);
        check_all();
        input_imm = 16'b0100000_000000_001;
        expect_out("br_pos", SEL_IMM, 16'h0040);
        check_all();
        input_branch = 1'b0;
        expect_out("2ri_pos", SEL_IMM, 16'h0020);
        check_all();

        // Reset asserted between edges clears everything immediately.
        input_imm = {3'b000, 6'h15, 4'h0, 3'b010};
        #2;
        RESET_N = 1'b0;
        read_pair(3'd1, 3'd7, 16'h0000, 16'h0000, "rst_mid");
        expect_out("rst_mid_imm", SEL_IMM, 16'h0015);
        check_all();

        // Write and L-type attempted across an edge while in reset.
        @(negedge CLK);
        input_reg_write         = 1'b1;
        input_reg_write_address = 3'd4;
        memToReg                = 1'b1;
        input_MDR               = 16'hAAAA;
        input_imm               = {3'b000, 10'h3FF, 3'b011};
        @(posedge CLK);
        @(negedge CLK);
        input_reg_write = 1'b0;
        input_imm       = {3'b000, 6'h15, 4'h0, 3'b010};
        read_pair(3'd4, 3'd0, 16'h0000, 16'h0000, "rst_wr");
        expect_out("rst_ui", SEL_IMM, 16'h0015);
        check_all();

        // First write lands on the first edge after release.
        RESET_N = 1'b1;
        do_write(3'd5, 16'h5555, 1'b0);
        read_pair(3'd5, 3'd4, 16'h5555, 16'h0000, "post_rst");
        expect_out("post_rst_imm", SEL_IMM, 16'h0015);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
